// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
// Round-robin sharing of one cv32e40p_mult between NUM_REQ requesters.
// One operation in flight: operands are held for the whole sequence, and the result is held until it is accepted.
module mult_share_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 32,
  parameter int OP_W        = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
  input  logic [NUM_REQ*2-1:0]      req_signed_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_result_o,
  output logic                      rsp_err_o,
  output logic                      mult_enable_o,
  output logic [OP_W-1:0]           mult_operator_o,
  output logic [1:0]                mult_short_signed_o,
  output logic [DATA_W-1:0]         mult_op_a_o,
  output logic [DATA_W-1:0]         mult_op_b_o,
  output logic                      mult_ex_ready_o,
  input  logic [DATA_W-1:0]         mult_result_i,
  input  logic                      mult_ready_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [OP_W-1:0] MUL_MAC32 = OP_W'(0);
  localparam logic [OP_W-1:0] MUL_H     = OP_W'(6);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0]  r_grant_oh;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mult_en;
  logic [OP_W-1:0]     r_op;
  logic [1:0]          r_sgn;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_result;
  logic                r_err;

  logic [NUM_REQ-1:0]  w_hi_mask;
  logic [NUM_REQ-1:0]  w_hi_req;
  logic [NUM_REQ-1:0]  w_pick;
  logic [PTR_W-1:0]    w_grant_idx;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic                w_grant_any;
  logic [OP_W-1:0]     w_sel_op;
  logic [1:0]          w_sel_sgn;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic                w_sel_legal;
  logic                w_timeout;
  logic                w_rsp_taken;

  // Round robin: prefer requesters above the last grant, then wrap around to the lowest index.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and infers a latch.
    w_hi_mask   = '0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_hi_mask[i] = (PTR_W'(i) > r_ptr);
    end
    w_hi_req    = req_valid_i & w_hi_mask;
    w_pick      = (|w_hi_req) ? w_hi_req : req_valid_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        w_grant_idx = PTR_W'(i);
      end
    end
    w_grant_any = |req_valid_i;
    if (w_grant_any) begin
      w_grant_oh[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    w_sel_op  = '0;
    w_sel_sgn = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == PTR_W'(i)) begin
        w_sel_op  = req_op_i[i*OP_W +: OP_W];
        w_sel_sgn = req_signed_i[i*2 +: 2];
        w_sel_a   = req_a_i[i*DATA_W +: DATA_W];
        w_sel_b   = req_b_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_sel_legal = (w_sel_op == MUL_MAC32) || (w_sel_op == MUL_H);
  assign w_timeout   = r_mult_en && !mult_ready_i && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_rsp_taken = |(rsp_ready_i & r_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= PTR_W'(NUM_REQ - 1);
      r_grant_oh  <= '0;
      r_cnt       <= '0;
      r_mult_en   <= 1'b0;
      r_op        <= '0;
      r_sgn       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_ptr      <= w_grant_idx;
            r_grant_oh <= w_grant_oh;
            if (w_sel_legal) begin
              r_state   <= S_BUSY;
              r_mult_en <= 1'b1;
              r_cnt     <= '0;
              r_op      <= w_sel_op;
              r_sgn     <= w_sel_sgn;
              r_a       <= w_sel_a;
              r_b       <= w_sel_b;
            end else begin
              // The multiplier never sees an illegal opcode; answer with an error directly.
              r_state     <= S_RESP;
              r_rsp_valid <= w_grant_oh;
              r_result    <= '0;
              r_err       <= 1'b1;
            end
          end
        end

        S_BUSY: begin
          if (mult_ready_i || w_timeout) begin
            r_state     <= S_RESP;
            r_mult_en   <= 1'b0;
            r_op        <= '0;
            r_sgn       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= r_grant_oh;
            r_result    <= mult_ready_i ? mult_result_i : '0;
            r_err       <= !mult_ready_i;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          if (w_rsp_taken) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o         = (r_state == S_IDLE) ? w_grant_oh : '0;
  assign rsp_valid_o         = r_rsp_valid;
  assign rsp_result_o        = r_result;
  assign rsp_err_o           = r_err;
  assign mult_enable_o       = r_mult_en;
  assign mult_operator_o     = r_op;
  assign mult_short_signed_o = r_sgn;
  assign mult_op_a_o         = r_a;
  assign mult_op_b_o         = r_b;
  // On a timeout the pulse releases the multiplier's internal sequence.
  assign mult_ex_ready_o     = r_mult_en && (mult_ready_i || w_timeout);

endmodule
